// File: rtl/ball_vertical_control_if.sv
// rtl/ball_vertical_control_if.sv - detector inputs and velocity/load outputs of the ball vertical sequencer
interface ball_vertical_control_if;
  logic       attract;
  logic       hit;
  logic [2:0] paddle_seg;
  logic       wall_hit;
  logic       vblank;
  logic [3:0] vload;
  logic       vload_stb;
  logic       vel_dir;
  logic [1:0] vel_mag;
  logic       holdoff;

  modport master (
    output attract, hit, paddle_seg, wall_hit, vblank,
    input  vload, vload_stb, vel_dir, vel_mag, holdoff
  );

  modport slave (
    input  attract, hit, paddle_seg, wall_hit, vblank,
    output vload, vload_stb, vel_dir, vel_mag, holdoff
  );
endinterface

// File: rtl/ball_vertical_control.sv
// rtl/ball_vertical_control.sv - paddle-hit velocity capture, wall reversal and per-frame vertical load
module ball_vertical_control #(
  parameter int BASE_LOAD    = 7,
  parameter int HOLDOFF_CLKS = 1024,
  parameter int HOLDOFF_W    = 11
) (
  input  logic                    clk,
  input  logic                    _reset,
  ball_vertical_control_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_ATTRACT = 2'd0,
    ST_PLAY    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_e;

  localparam logic [3:0]           BASE4     = 4'(BASE_LOAD);
  localparam logic [HOLDOFF_W-1:0] HOLD_INIT = HOLDOFF_W'(HOLDOFF_CLKS);
  localparam logic [HOLDOFF_W-1:0] HOLD_ONE  = HOLDOFF_W'(1);

  state_e               state_q, state_d;
  logic                 hit_q, hit_d, hit_prev_q, hit_prev_d;
  logic                 wall_q, wall_d, wall_prev_q, wall_prev_d;
  logic                 vb_q, vb_d, vb_prev_q, vb_prev_d;
  logic [2:0]           seg_q, seg_d;
  logic                 dir_q, dir_d;
  logic [1:0]           mag_q, mag_d;
  logic [HOLDOFF_W-1:0] cnt_q, cnt_d;
  logic [3:0]           vload_q, vload_d;
  logic                 stb_q, stb_d;

  logic hit_rise, wall_rise, vb_rise;

  assign hit_rise  = hit_q  & ~hit_prev_q;
  assign wall_rise = wall_q & ~wall_prev_q;
  assign vb_rise   = vb_q   & ~vb_prev_q;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    vload_d     = vload_q;
    stb_d       = vb_rise;
    hit_d       = bus.hit;
    hit_prev_d  = hit_q;
    seg_d       = bus.paddle_seg;
    wall_d      = bus.wall_hit;
    wall_prev_d = wall_q;
    vb_d        = bus.vblank;
    vb_prev_d   = vb_q;

    // Load is computed from the velocity currently held, so same-cycle updates land next frame.
    if (vb_rise) begin
      vload_d = dir_q ? (BASE4 + {2'b00, mag_q}) : (BASE4 - {2'b00, mag_q});
    end

    if (bus.attract) begin
      state_d = ST_ATTRACT;
      mag_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_ATTRACT: begin
          state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (hit_rise) begin
            // Top half of the paddle sends the ball up, faster towards the tip.
            dir_d   = seg_q[2];
            mag_d   = seg_q[2] ? seg_q[1:0] : ~seg_q[1:0];
            cnt_d   = HOLD_INIT;
            state_d = ST_LOCKOUT;
          end else if (wall_rise) begin
            dir_d = ~dir_q;
          end
        end
        ST_LOCKOUT: begin
          if (wall_rise) begin
            dir_d = ~dir_q;
          end
          if (cnt_q <= HOLD_ONE) begin
            cnt_d   = '0;
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q - HOLD_ONE;
          end
        end
        default: begin
          state_d = ST_PLAY;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Reset lands in PLAY: edge registers are clear, so the first clock cannot capture,
  // and a held attract moves the machine to ATTRACT on that same clock.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q     <= ST_PLAY;
      hit_q       <= 1'b0;
      hit_prev_q  <= 1'b0;
      wall_q      <= 1'b0;
      wall_prev_q <= 1'b0;
      vb_q        <= 1'b0;
      vb_prev_q   <= 1'b0;
      seg_q       <= 3'd0;
      dir_q       <= 1'b0;
      mag_q       <= 2'd0;
      cnt_q       <= '0;
      vload_q     <= BASE4;
      stb_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hit_q       <= hit_d;
      hit_prev_q  <= hit_prev_d;
      wall_q      <= wall_d;
      wall_prev_q <= wall_prev_d;
      vb_q        <= vb_d;
      vb_prev_q   <= vb_prev_d;
      seg_q       <= seg_d;
      dir_q       <= dir_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      vload_q     <= vload_d;
      stb_q       <= stb_d;
    end
  end

  assign bus.vload     = vload_q;
  assign bus.vload_stb = stb_q;
  assign bus.vel_dir   = dir_q;
  assign bus.vel_mag   = mag_q;
  assign bus.holdoff   = (state_q == ST_LOCKOUT);

endmodule

// File: tb/tb_ball_vertical_control.sv
// tb/tb_ball_vertical_control.sv - self-checking bench for ball_vertical_control
module tb_ball_vertical_control;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [3:0] sb[$];

  ball_vertical_control_if bus ();

  ball_vertical_control #(
    .BASE_LOAD   (7),
    .HOLDOFF_CLKS(1024),
    .HOLDOFF_W   (11)
  ) dut (
    .clk   (clk),
    ._reset(rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0] seg;
    logic       dir;
    logic [1:0] mag;
    logic [3:0] vload;
  } vec_t;

  vec_t vecs[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_hit(input logic [2:0] seg);
    bus.paddle_seg = seg;
    bus.hit = 1'b1;
    tick();
    bus.hit = 1'b0;
  endtask

  task automatic pulse_vblank(input logic [3:0] exp);
    bus.vblank = 1'b1;
    sb.push_back(exp);
    tick();
    bus.vblank = 1'b0;
    repeat (3) tick();
  endtask

  task automatic wait_lockout(output int n);
    n = 0;
    while (bus.holdoff && n < 2000) begin
      n++;
      tick();
    end
  endtask

  // Strobe monitor: every strobe must match the oldest outstanding vblank expectation.
  always @(posedge clk) begin
    #2;
    if (rst_n && bus.vload_stb) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_stb actual=1 expected=0 vload=%0d", bus.vload);
      end else begin
        check("stb_vload", bus.vload, sb.pop_front());
      end
    end
  end

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    vecs[0] = '{3'd0, 1'b0, 2'd3, 4'd4};
    vecs[1] = '{3'd1, 1'b0, 2'd2, 4'd5};
    vecs[2] = '{3'd2, 1'b0, 2'd1, 4'd6};
    vecs[3] = '{3'd3, 1'b0, 2'd0, 4'd7};
    vecs[4] = '{3'd4, 1'b1, 2'd0, 4'd7};
    vecs[5] = '{3'd5, 1'b1, 2'd1, 4'd8};
    vecs[6] = '{3'd6, 1'b1, 2'd2, 4'd9};
    vecs[7] = '{3'd7, 1'b1, 2'd3, 4'd10};

    bus.attract    = 1'b0;
    bus.hit        = 1'b0;
    bus.paddle_seg = 3'd0;
    bus.wall_hit   = 1'b0;
    bus.vblank     = 1'b0;
    rst_n          = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_vload", bus.vload, 7);
    check("rst_stb", bus.vload_stb, 0);
    check("rst_dir", bus.vel_dir, 0);
    check("rst_mag", bus.vel_mag, 0);
    check("rst_holdoff", bus.holdoff, 0);

    // vblank held high strobes once
    bus.vblank = 1'b1;
    sb.push_back(4'd7);
    repeat (6) tick();
    bus.vblank = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 8; i++) begin
      pulse_hit(vecs[i].seg);
      tick();
      check($sformatf("vec%0d_dir", i), bus.vel_dir, vecs[i].dir);
      check($sformatf("vec%0d_mag", i), bus.vel_mag, vecs[i].mag);
      check($sformatf("vec%0d_holdoff", i), bus.holdoff, 1);
      wait_lockout(n);
      check($sformatf("vec%0d_lockout_len", i), n, 1024);
      pulse_vblank(vecs[i].vload);
    end

    // second hit inside lockout is ignored and does not extend it
    pulse_hit(3'd6);
    tick();
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!bus.holdoff) break;
      n++;
      bus.hit = (i == 100);
      bus.paddle_seg = (i == 100) ? 3'd0 : 3'd6;
      tick();
    end
    bus.hit = 1'b0;
    check("rehit_lockout_len", n, 1024);
    check("rehit_dir", bus.vel_dir, 1);
    check("rehit_mag", bus.vel_mag, 2);
    pulse_vblank(4'd9);

    // wall reversal, then hit and wall together
    bus.wall_hit = 1'b1;
    tick();
    bus.wall_hit = 1'b0;
    tick();
    check("wall_dir", bus.vel_dir, 0);
    check("wall_mag", bus.vel_mag, 2);
    pulse_vblank(4'd5);
    bus.paddle_seg = 3'd1;
    bus.hit = 1'b1;
    bus.wall_hit = 1'b1;
    tick();
    bus.hit = 1'b0;
    bus.wall_hit = 1'b0;
    tick();
    check("hitwall_dir", bus.vel_dir, 0);
    check("hitwall_mag", bus.vel_mag, 2);
    check("hitwall_holdoff", bus.holdoff, 1);
    wait_lockout(n);
    check("hitwall_lockout_len", n, 1024);

    // vblank coincident with a wall toggle uses the old direction
    pulse_hit(3'd7);
    tick();
    wait_lockout(n);
    bus.wall_hit = 1'b1;
    bus.vblank = 1'b1;
    sb.push_back(4'd10);
    tick();
    bus.wall_hit = 1'b0;
    bus.vblank = 1'b0;
    repeat (2) tick();
    check("vbwall_dir", bus.vel_dir, 0);
    check("vbwall_mag", bus.vel_mag, 3);
    pulse_vblank(4'd4);

    // hit held across lockout expiry does not recapture
    pulse_hit(3'd0);
    bus.hit = 1'b1;
    bus.paddle_seg = 3'd7;
    tick();
    wait_lockout(n);
    check("held_lockout_len", n, 1024);
    repeat (5) tick();
    check("held_holdoff", bus.holdoff, 0);
    check("held_dir", bus.vel_dir, 0);
    check("held_mag", bus.vel_mag, 3);
    bus.hit = 1'b0;
    tick();

    // attract during lockout
    pulse_hit(3'd5);
    tick();
    repeat (10) tick();
    check("pre_attract_holdoff", bus.holdoff, 1);
    bus.attract = 1'b1;
    tick();
    check("attract_mag", bus.vel_mag, 0);
    check("attract_holdoff", bus.holdoff, 0);
    check("attract_dir", bus.vel_dir, 1);
    pulse_hit(3'd0);
    tick();
    check("attract_hit_mag", bus.vel_mag, 0);
    check("attract_hit_dir", bus.vel_dir, 1);
    check("attract_hit_holdoff", bus.holdoff, 0);
    pulse_vblank(4'd7);
    bus.attract = 1'b0;
    repeat (2) tick();

    // asynchronous reset mid-lockout
    pulse_hit(3'd5);
    tick();
    pulse_vblank(4'd8);
    check("prereset_vload", bus.vload, 8);
    check("prereset_holdoff", bus.holdoff, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_vload", bus.vload, 7);
    check("async_stb", bus.vload_stb, 0);
    check("async_dir", bus.vel_dir, 0);
    check("async_mag", bus.vel_mag, 0);
    check("async_holdoff", bus.holdoff, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ball_vertical_control.md
Name: ball_vertical_control

Overview:
Clocked sequencer for the ball vertical-motion datapath. It captures the struck paddle segment on a ball/paddle hit and converts it into a signed vertical velocity. It also reverses direction on top/bottom wall contact and produces the per-frame vertical-counter load value with a one-cycle load strobe at the start of vertical blank. It sits between the hit/wall detectors and the ball vertical counter, replacing the free-running flip-flop/adder chain with a single-clock state machine.

Parameters:
BASE_LOAD, 7, load value for zero vertical velocity; legal range 3..12.
HOLDOFF_CLKS, 1024, clocks for which further hit edges are ignored after a capture; must be >= 1.
HOLDOFF_W, 11, width of the holdoff counter; must satisfy 2^HOLDOFF_W > HOLDOFF_CLKS.

Ports:
clk  in  1  system clock
_reset  in  1  asynchronous active-low reset
attract  in  1  attract/demo mode; high forces velocity to zero
hit  in  1  level; ball overlaps a paddle
paddle_seg  in  3  paddle segment under the ball, 0 = top, 7 = bottom; sampled with hit
wall_hit  in  1  level; ball touches top or bottom wall
vblank  in  1  vertical blank level
vload  out  4  vertical counter load value
vload_stb  out  1  one-cycle pulse; vload valid for the coming frame
vel_dir  out  1  current direction, 0 = up, 1 = down
vel_mag  out  2  current speed magnitude, 0..3
holdoff  out  1  high while hit capture is locked out

Behaviour:
- Reset: _reset is asynchronous, active low; one clock and one reset; no other clock domains. While _reset is low, all state clears immediately:
  - vload = BASE_LOAD, vload_stb = 0, vel_dir = 0, vel_mag = 0, holdoff = 0.
  - State = ATTRACT if attract is high at release, else PLAY.
  - All edge-detect registers clear to 0.
- Edge detect: hit, wall_hit and vblank are each registered once; a rise is current = 1 and previous = 0. There are no metastability synchronisers; inputs are already in the clk domain.
- States: ATTRACT, PLAY, LOCKOUT.
  - ATTRACT: vel_mag held at 0, vel_dir held. Hit and wall edges are ignored. Exit to PLAY on the first clock with attract = 0.
  - PLAY: a hit rise captures paddle_seg.
    - seg 0..3: vel_dir = 0, vel_mag = 3 - seg.
    - seg 4..7: vel_dir = 1, vel_mag = seg - 4.
    - After a capture, load the holdoff counter with HOLDOFF_CLKS and go to LOCKOUT.
    - A wall_hit rise toggles vel_dir; vel_mag is unchanged.
  - LOCKOUT: holdoff = 1. The counter decrements each clock and hit rises are ignored. Wall rises still toggle vel_dir. When the counter reaches 1, the next clock enters PLAY with holdoff = 0. LOCKOUT lasts exactly HOLDOFF_CLKS cycles.
  - attract = 1 in any state: next state is ATTRACT, vel_mag = 0, and the holdoff counter clears. This overrides everything else.
- Simultaneous events:
  - A hit rise and a wall rise in the same PLAY cycle: the hit capture wins and the wall edge is discarded.
  - A vblank rise in the same cycle as a capture or toggle: vload uses the pre-update vel_dir/vel_mag. The new velocity applies from the next frame.
- Load generation, on each vblank rise, in every state:
  - vload <= BASE_LOAD + vel_mag if vel_dir = 1, else BASE_LOAD - vel_mag.
  - Arithmetic is 4-bit modulo 16 with no saturation; the legal BASE_LOAD range guarantees no wrap.
  - vload_stb = 1 for exactly the cycle after the vblank rise edge is detected (registered output), and 0 otherwise.
  - vload holds its value between strobes.
- Latency: input rise to vel_dir/vel_mag update is 2 clocks (1 for the edge register, 1 for the state register). vblank rise to vload/vload_stb is 2 clocks.
- vblank held high does not re-strobe. hit held high across LOCKOUT expiry does not re-capture, because a new rise is required.

Test Plan:
1. Reset with attract = 0, then release: vload = 7, vload_stb = 0, vel_mag = 0, vel_dir = 0, state PLAY. Pulse vblank: vload_stb high exactly 1 cycle, vload = 7.
2. Hit with paddle_seg = 0, then vblank: vel_dir = 0, vel_mag = 3, vload = 4. Repeat after holdoff with seg = 7: vel_dir = 1, vel_mag = 3, vload = 10. Seg = 3 gives vload = 7 up; seg = 4 gives vload = 7 down.
3. Hit with seg = 6, then a second hit rise with seg = 0 within 1024 clocks: holdoff = 1 for exactly 1024 cycles. Velocity stays down/2 and the next vblank gives vload = 9.
4. Velocity down/2, then a wall_hit rise followed by vblank: vel_dir = 0 and vload = 5. A hit rise (seg = 1) and a wall_hit rise in the same cycle: vel_dir = 0, vel_mag = 2, no toggle.
5. Velocity down/3, then a vblank rise in the same cycle as a wall rise: that strobe carries vload = 10 and the following frame's strobe carries vload = 4.
6. attract asserted in LOCKOUT: vel_mag = 0 and holdoff = 0 the next cycle, hits are ignored, and vblank gives vload = 7. Assert _reset mid-LOCKOUT: outputs return to reset values asynchronously, without waiting for a clk edge.
